div_reconstruct: RTL and testbench

Sequential shift-add multiply-accumulate unit that computes A = Q·B + R, the inverse of the restoring divider (`TOP`) in the same design. It takes a quotient, divisor and remainder from that divider, or from any other source, and rebuilds the dividend one multiplier bit per clock. It also flags two conditions: a result too wide to have come from an N-bit dividend, and a remainder that is not smaller than the divisor. It sits beside the divider as its self-check and round-trip partner, using the same Start/Busy handshake.

---
 rtl/div_reconstruct.sv | 123 ++++++++++++
 tb/tb_div_reconstruct.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/div_reconstruct.sv
// Shift-add reconstruction A = Q*B + R. It is the round-trip partner of the restoring divider.
// One multiplier bit is consumed per clock. The iteration count is fixed, so latency is always N cycles.
module div_reconstruct #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [N-1:0]     InQ,
  input  logic [N-1:0]     InB,
  input  logic [N-1:0]     InR,
  output logic [2*N-1:0]   Out_A,
  output logic             Ovf,
  output logic             RemErr,
  output logic             Busy,
  output logic             Done
);

  // state  | meaning
  // S_IDLE | waiting for Start; result registers hold
  // S_CALC | one shift-add iteration per clock, N iterations total
  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  localparam int W  = 2 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   mult_q, mult_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rem_cand_q, rem_cand_d;
  logic [W-1:0]   out_a_q, out_a_d;
  logic           ovf_q, ovf_d;
  logic           rem_err_q, rem_err_d;
  logic           done_q, done_d;

  logic [W-1:0]   sum;

  // The bound (2^N-1)^2 + 2^N-1 < 2^2N means the 2N-bit sum never carries out.
  always_comb begin
    sum = acc_q + (mult_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d    = state_q;
    mult_d     = mult_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rem_cand_d = rem_cand_q;
    out_a_d    = out_a_q;
    ovf_d      = ovf_q;
    rem_err_d  = rem_err_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mult_d     = InQ;
          mcand_d    = {{N{1'b0}}, InB};
          acc_d      = {{N{1'b0}}, InR};
          cnt_d      = '0;
          rem_cand_d = (InR >= InB);
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          out_a_d   = sum;
          ovf_d     = |sum[W-1:N];
          rem_err_d = rem_cand_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mult_q     <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rem_cand_q <= 1'b0;
      out_a_q    <= '0;
      ovf_q      <= 1'b0;
      rem_err_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mult_q     <= mult_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rem_cand_q <= rem_cand_d;
      out_a_q    <= out_a_d;
      ovf_q      <= ovf_d;
      rem_err_q  <= rem_err_d;
      done_q     <= done_d;
    end
  end

  assign Out_A  = out_a_q;
  assign Ovf    = ovf_q;
  assign RemErr = rem_err_q;
  assign Done   = done_q;
  assign Busy   = (state_q == S_CALC);

endmodule

// File: tb/tb_div_reconstruct.sv
// Directed bench for div_reconstruct (N=8). It checks round-trip values, flags, latency, reset abort and back-to-back operation.
module tb_div_reconstruct;
  localparam int N = 8;

  logic             clk;
  logic             rst;
  logic             Start;
  logic [N-1:0]     InQ, InB, InR;
  logic [2*N-1:0]   Out_A;
  logic             Ovf, RemErr, Busy, Done;

  int n_cmp = 0;
  int n_err = 0;

  div_reconstruct #(.N(N)) dut (
    .clk(clk), .rst(rst), .Start(Start),
    .InQ(InQ), .InB(InB), .InR(InR),
    .Out_A(Out_A), .Ovf(Ovf), .RemErr(RemErr), .Busy(Busy), .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges stepped until Done is seen. A timeout counts as a failure.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!Done && cyc < 40);
    check({tag, "_done_seen"}, 32'(Done), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] q, input logic [7:0] b, input logic [7:0] r,
                        input logic [15:0] exp_a, input logic exp_ovf, input logic exp_rem);
    int cyc;
    InQ = q; InB = b; InR = r; Start = 1'b1;
    step();
    Start = 1'b0;
    wait_done(tag, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(N));
    check({tag, "_out_a"},   32'(Out_A), 32'(exp_a));
    check({tag, "_ovf"},     32'(Ovf), 32'(exp_ovf));
    check({tag, "_remerr"},  32'(RemErr), 32'(exp_rem));
    check({tag, "_busy"},    32'(Busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int done_seen;
    rst = 1'b1; Start = 1'b0; InQ = '0; InB = '0; InR = '0;
    step();
    step();
    check("rst_out_a",  32'(Out_A), 32'd0);
    check("rst_ovf",    32'(Ovf), 32'd0);
    check("rst_remerr", 32'(RemErr), 32'd0);
    check("rst_busy",   32'(Busy), 32'd0);
    check("rst_done",   32'(Done), 32'd0);

    // reset together with Start: the request is dropped
    Start = 1'b1; InQ = 8'h11; InB = 8'h05;
    step();
    Start = 1'b0;
    check("rst_start_busy", 32'(Busy), 32'd0);
    rst = 1'b0;
    step();
    check("rst_start_idle", 32'(Busy), 32'd0);

    run_op("rt1", 8'h11, 8'h05, 8'h00, 16'h0055, 1'b0, 1'b0);
    run_op("rt2", 8'h06, 8'h15, 8'h07, 16'h0085, 1'b0, 1'b0);
    run_op("rt3", 8'h37, 8'h03, 8'h00, 16'h00A5, 1'b0, 1'b0);
    run_op("rt4", 8'h33, 8'h05, 8'h00, 16'h00FF, 1'b0, 1'b0);
    run_op("ovf", 8'hFF, 8'hFF, 8'hFF, 16'hFF00, 1'b1, 1'b1);
    run_op("remerr", 8'd3, 8'd4, 8'd9, 16'h0015, 1'b0, 1'b1);
    run_op("zeros", 8'd0, 8'd0, 8'd0, 16'h0000, 1'b0, 1'b1);

    // Handshake timing, with a Start injected mid-operation that must be ignored
    InQ = 8'h06; InB = 8'h15; InR = 8'h07; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("hs_busy_%0d", i), 32'(Busy), (i < N) ? 32'd1 : 32'd0);
      check($sformatf("hs_done_%0d", i), 32'(Done), (i == N) ? 32'd1 : 32'd0);
      if (i == N) check("hs_out_a", 32'(Out_A), 32'h0085);
      if (i == 2) begin
        InQ = 8'hFF; InB = 8'hFF; InR = 8'h00; Start = 1'b1;
      end
      if (i == 3) Start = 1'b0;
      step();
    end
    check("hs_out_a_hold", 32'(Out_A), 32'h0085);

    // Reset at iteration 4 aborts the operation and clears the outputs
    InQ = 8'h11; InB = 8'h05; InR = 8'h00; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (4) step();
    check("mid_busy_before", 32'(Busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_out_a",  32'(Out_A), 32'd0);
    check("mid_ovf",    32'(Ovf), 32'd0);
    check("mid_remerr", 32'(RemErr), 32'd0);
    check("mid_busy",   32'(Busy), 32'd0);
    check("mid_done",   32'(Done), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (Done || Busy) done_seen++;
    end
    check("mid_no_done", 32'(done_seen), 32'd0);
    run_op("after_rst", 8'h11, 8'h05, 8'h00, 16'h0055, 1'b0, 1'b0);

    // Start held high: one result every N+1 cycles
    InQ = 8'h0A; InB = 8'h0A; InR = 8'h01; Start = 1'b1;
    wait_done("b2b0", cyc);
    check("b2b0_out_a", 32'(Out_A), 32'h0065);
    for (int k = 1; k <= 3; k++) begin
      wait_done($sformatf("b2b%0d", k), cyc);
      check($sformatf("b2b%0d_period", k), 32'(cyc), 32'(N + 1));
      check($sformatf("b2b%0d_out_a", k), 32'(Out_A), 32'h0065);
      check($sformatf("b2b%0d_remerr", k), 32'(RemErr), 32'd0);
    end
    Start = 1'b0;
    step();
    check("b2b_done_width", 32'(Done), 32'd0);
    check("b2b_stopped", 32'(Busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
